input_conditioner: RTL

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 15 +
 rtl/btn_debounce_fsm.sv | 114 +++++++++++
 rtl/input_conditioner.sv | 80 ++++++++
 3 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the push-button / switch input conditioner.
package input_conditioner_pkg;

  // Debounce FSM states. Level output is high in ST_HELD and ST_RELEASE_WAIT.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_t;

  // Default stable-sample count needed to accept a level change.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One push-button channel: 2-flop synchronizer, debounce counter and FSM,
// registered one-cycle press pulse and debounced level.
//
// state           | meaning
// ----------------+---------------------------------------------------
// ST_IDLE         | button released and accepted as released
// ST_PRESS_WAIT   | sync high, counting stable samples toward a press
// ST_HELD         | press accepted, pulse already issued
// ST_RELEASE_WAIT | sync low, counting stable samples toward a release
module btn_debounce_fsm
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level,
  output logic o_accept
);

  localparam int unsigned     CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Next-state logic; the counter saturates at CNT_TC because reaching it
  // always forces a state change that reloads it.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_count_nxt = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else if (r_count == CNT_TC) begin
          w_state_nxt = ST_HELD;
          w_count_nxt = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!r_sync2) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_count_nxt = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = ST_HELD;
          w_count_nxt = '0;
        end else if (r_count == CNT_TC) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_pulse  = r_pulse;
  assign o_level  = (r_state == ST_HELD) || (r_state == ST_RELEASE_WAIT);
  // Asserted in the cycle before o_pulse so a consumer can capture data on
  // the same edge that raises the pulse.
  assign o_accept = w_pulse_nxt;

endmodule

// File: rtl/input_conditioner.sv
// Conditions two raw push-buttons and a slide-switch bus: debounced press
// pulses and levels per button, and a switch snapshot on every right press.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SW_WIDTH        = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btnL,
  input  logic                btnR,
  input  logic [SW_WIDTH-1:0] SWs,
  output logic                left_pulse,
  output logic                right_pulse,
  output logic                left_level,
  output logic                right_level,
  output logic [SW_WIDTH-1:0] SWs_snap,
  output logic                snap_valid
);

  logic [SW_WIDTH-1:0] r_sw_sync1;
  logic [SW_WIDTH-1:0] r_sw_sync2;
  logic [SW_WIDTH-1:0] r_sw_snap;
  logic                r_snap_valid;
  logic                w_left_accept;
  logic                w_right_accept;

  btn_debounce_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_btn    (btnL),
    .o_pulse  (left_pulse),
    .o_level  (left_level),
    .o_accept (w_left_accept)
  );

  btn_debounce_fsm #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_btn    (btnR),
    .o_pulse  (right_pulse),
    .o_level  (right_level),
    .o_accept (w_right_accept)
  );

  // Per-bit two-flop synchronizer for the switches; switches are not debounced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
    end else begin
      r_sw_sync1 <= SWs;
      r_sw_sync2 <= r_sw_sync1;
    end
  end

  // Capture the switches on the edge that raises right_pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_snap    <= '0;
      r_snap_valid <= 1'b0;
    end else if (w_right_accept) begin
      r_sw_snap    <= r_sw_sync2;
      r_snap_valid <= 1'b1;
    end
  end

  assign SWs_snap   = r_sw_snap;
  assign snap_valid = r_snap_valid;

  // Left accept strobe is not needed at this level.
  logic w_unused;
  assign w_unused = w_left_accept;

endmodule
